// File: rtl/mem_ctrl_pkg.sv
// Shared widths, size encodings, state encoding and the IO address predicate
// for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int INS_W  = 32;
  localparam int BYTE_W = 8;

  // Access size encodings used by the load/store buffer.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Address bits [17:16] equal to this tag select the memory-mapped IO space.
  localparam logic [1:0] IO_ADDR_TAG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STORE  = 2'd3
  } state_e;

  // Number of bytes moved for a given size code; unknown codes move a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and LSB
// loads/stores onto one 8-bit RAM/IO bus, with fetch drop and ROB rollback.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,

  input  logic [BYTE_W-1:0]   mem_din,
  output logic [BYTE_W-1:0]   mem_dout,
  output logic [ADDR_W-1:0]   mem_a,
  output logic                mem_wr,
  input  logic                io_buffer_full,

  input  logic                ena_from_if,
  input  logic [ADDR_W-1:0]   pc_from_if,
  input  logic                drop_flag_from_if,
  output logic                ok_flag_to_if,
  output logic [INS_W-1:0]    inst_to_if,

  input  logic                ena_from_lsb,
  input  logic                wr_flag_from_lsb,
  input  logic [ADDR_W-1:0]   addr_from_lsb,
  input  logic [DATA_W-1:0]   data_from_lsb,
  input  logic [1:0]          size_from_lsb,
  output logic                ok_flag_to_lsb,
  output logic [DATA_W-1:0]   data_to_lsb,
  input  logic                rollback_flag_from_rob
);

  // Transfer state and byte sequencing.
  state_e              r_state;
  logic [2:0]          r_stage;
  logic [DATA_W-1:0]   r_buf;

  // Latched client requests.
  logic                r_if_pending;
  logic [ADDR_W-1:0]   r_if_pc;
  logic                r_lsb_pending;
  logic                r_lsb_wr;
  logic [ADDR_W-1:0]   r_lsb_addr;
  logic [DATA_W-1:0]   r_lsb_data;
  logic [1:0]          r_lsb_size;

  // Registered bus and client outputs.
  logic [ADDR_W-1:0]   r_mem_a;
  logic [BYTE_W-1:0]   r_mem_dout;
  logic                r_mem_wr;
  logic                r_ok_if;
  logic                r_ok_lsb;
  logic [INS_W-1:0]    r_inst;
  logic [DATA_W-1:0]   r_data;

  // Combinational views.
  state_e              w_state_next;
  logic                w_done;
  logic                w_if_req;
  logic [ADDR_W-1:0]   w_if_pc;
  logic                w_lsb_req;
  logic                w_lsb_wr;
  logic [ADDR_W-1:0]   w_lsb_addr;
  logic [DATA_W-1:0]   w_lsb_data;
  logic                w_io_stall;
  logic [2:0]          w_len;
  logic [ADDR_W-1:0]   w_base;
  logic [1:0]          w_cap_idx;
  logic [1:0]          w_last_idx;
  logic [DATA_W-1:0]   w_rd_word;

  // A request pulsing this edge is visible to arbitration this same edge.
  assign w_if_pc    = ena_from_if  ? pc_from_if       : r_if_pc;
  assign w_lsb_wr   = ena_from_lsb ? wr_flag_from_lsb : r_lsb_wr;
  assign w_lsb_addr = ena_from_lsb ? addr_from_lsb    : r_lsb_addr;
  assign w_lsb_data = ena_from_lsb ? data_from_lsb    : r_lsb_data;

  // A drop only kills the old fetch; a fetch pulsed alongside it survives.
  assign w_if_req   = ena_from_if | (r_if_pending & ~drop_flag_from_if);
  // Rollback flushes loads only; stores reaching us are already committed.
  assign w_lsb_req  = (ena_from_lsb | r_lsb_pending) & ~(rollback_flag_from_rob & ~w_lsb_wr);
  // IO stores wait for UART space; fetches wait behind them to keep order.
  assign w_io_stall = w_lsb_req & w_lsb_wr & io_buffer_full &
                      (w_lsb_addr[17:16] == IO_ADDR_TAG);

  assign w_len      = (r_state == ST_IFETCH) ? 3'd4 : size_to_len(r_lsb_size);
  assign w_base     = (r_state == ST_IFETCH) ? r_if_pc : r_lsb_addr;
  // Byte captured at stage k was addressed two edges earlier.
  assign w_cap_idx  = r_stage[1:0] - 2'd2;
  assign w_last_idx = w_len[1:0] - 2'd1;

  // Final read word: buffered bytes plus the last byte straight off the bus.
  always_comb begin
    w_rd_word = r_buf;
    w_rd_word[{w_last_idx, 3'b000} +: BYTE_W] = mem_din;
  end

  // Next-state and completion decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lsb_req) begin
          if (!w_io_stall) w_state_next = w_lsb_wr ? ST_STORE : ST_LOAD;
        end else if (w_if_req) begin
          w_state_next = ST_IFETCH;
        end
      end
      ST_IFETCH: begin
        if (drop_flag_from_if) begin
          w_state_next = ST_IDLE;
        end else if (r_stage == w_len + 3'd1) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      ST_LOAD: begin
        if (rollback_flag_from_rob) begin
          w_state_next = ST_IDLE;
        end else if (r_stage == w_len + 3'd1) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      ST_STORE: begin
        if (r_stage == w_len) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst)      r_state <= ST_IDLE;
    else if (rdy) r_state <= w_state_next;
  end

  // Request latches: clear on completion/drop/rollback, then set on new pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_pending  <= 1'b0;
      r_if_pc       <= '0;
      r_lsb_pending <= 1'b0;
      r_lsb_wr      <= 1'b0;
      r_lsb_addr    <= '0;
      r_lsb_data    <= '0;
      r_lsb_size    <= SIZE_B;
    end else if (rdy) begin
      if (drop_flag_from_if || (w_done && r_state == ST_IFETCH))
        r_if_pending <= 1'b0;
      if (ena_from_if) begin
        r_if_pending <= 1'b1;
        r_if_pc      <= pc_from_if;
      end
      if ((rollback_flag_from_rob && !r_lsb_wr) ||
          (w_done && (r_state == ST_LOAD || r_state == ST_STORE)))
        r_lsb_pending <= 1'b0;
      if (ena_from_lsb && !(rollback_flag_from_rob && !wr_flag_from_lsb)) begin
        r_lsb_pending <= 1'b1;
        r_lsb_wr      <= wr_flag_from_lsb;
        r_lsb_addr    <= addr_from_lsb;
        r_lsb_data    <= data_from_lsb;
        r_lsb_size    <= size_from_lsb;
      end
    end
  end

  // Bus sequencing, byte assembly and single-cycle ok pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage    <= 3'd0;
      r_buf      <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_ok_if    <= 1'b0;
      r_ok_lsb   <= 1'b0;
      r_inst     <= '0;
      r_data     <= '0;
    end else if (rdy) begin
      r_ok_if  <= 1'b0;
      r_ok_lsb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_state_next != ST_IDLE) begin
            r_stage <= 3'd1;
            r_buf   <= '0;
            r_mem_a <= (w_state_next == ST_IFETCH) ? w_if_pc : w_lsb_addr;
            if (w_state_next == ST_STORE) begin
              r_mem_wr   <= 1'b1;
              r_mem_dout <= w_lsb_data[BYTE_W-1:0];
            end
          end
        end
        ST_IFETCH, ST_LOAD: begin
          if (w_state_next == ST_IDLE) begin
            r_mem_a <= '0;
            if (w_done) begin
              if (r_state == ST_IFETCH) begin
                r_ok_if <= 1'b1;
                r_inst  <= w_rd_word;
              end else begin
                r_ok_lsb <= 1'b1;
                r_data   <= w_rd_word;
              end
            end
          end else begin
            r_stage <= r_stage + 3'd1;
            if (r_stage < w_len) r_mem_a <= w_base + {29'd0, r_stage};
            if (r_stage >= 3'd2) r_buf[{w_cap_idx, 3'b000} +: BYTE_W] <= mem_din;
          end
        end
        ST_STORE: begin
          if (w_done) begin
            r_mem_wr <= 1'b0;
            r_mem_a  <= '0;
            r_ok_lsb <= 1'b1;
          end else begin
            r_stage    <= r_stage + 3'd1;
            r_mem_a    <= r_lsb_addr + {29'd0, r_stage};
            r_mem_dout <= r_lsb_data[{r_stage[1:0], 3'b000} +: BYTE_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a          = r_mem_a;
  assign mem_dout       = r_mem_dout;
  // Write strobe is masked immediately when the core is not ready.
  assign mem_wr         = r_mem_wr & rdy;
  assign ok_flag_to_if  = r_ok_if;
  assign inst_to_if     = r_inst;
  assign ok_flag_to_lsb = r_ok_lsb;
  assign data_to_lsb    = r_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide synchronous RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ena_from_if, drop_flag_from_if, ok_flag_to_if;
  logic [31:0] pc_from_if, inst_to_if;
  logic        ena_from_lsb, wr_flag_from_lsb, ok_flag_to_lsb, rollback_flag_from_rob;
  logic [31:0] addr_from_lsb, data_from_lsb, data_to_lsb;
  logic [1:0]  size_from_lsb;

  int total = 0;
  int bad   = 0;
  int if_ok_cnt  = 0;
  int lsb_ok_cnt = 0;

  logic [7:0] ram [0:4095];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .mem_din                (mem_din),
    .mem_dout               (mem_dout),
    .mem_a                  (mem_a),
    .mem_wr                 (mem_wr),
    .io_buffer_full         (io_buffer_full),
    .ena_from_if            (ena_from_if),
    .pc_from_if             (pc_from_if),
    .drop_flag_from_if      (drop_flag_from_if),
    .ok_flag_to_if          (ok_flag_to_if),
    .inst_to_if             (inst_to_if),
    .ena_from_lsb           (ena_from_lsb),
    .wr_flag_from_lsb       (wr_flag_from_lsb),
    .addr_from_lsb          (addr_from_lsb),
    .data_from_lsb          (data_from_lsb),
    .size_from_lsb          (size_from_lsb),
    .ok_flag_to_lsb         (ok_flag_to_lsb),
    .data_to_lsb            (data_to_lsb),
    .rollback_flag_from_rob (rollback_flag_from_rob)
  );

  // RAM: registered read one cycle after the address; frozen with the core on rdy low.
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h93; ram[12'h201] = 8'h00; ram[12'h202] = 8'h10; ram[12'h203] = 8'h00;
    ram[12'h204] = 8'h34; ram[12'h205] = 8'h12;
    mem_din = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      if (rdy)    mem_din <= ram[mem_a[11:0]];
    end
  end

  // Count ok pulses once per cycle they are high.
  always @(negedge clk) begin
    if (ok_flag_to_if  === 1'b1) if_ok_cnt  <= if_ok_cnt + 1;
    if (ok_flag_to_lsb === 1'b1) lsb_ok_cnt <= lsb_ok_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Edges after the current one until the selected ok is seen; -1 on timeout.
  task automatic wait_ok(input bit lsb, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((lsb ? ok_flag_to_lsb : ok_flag_to_if) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_fetch(input logic [31:0] pc);
    pc_from_if  = pc;
    ena_from_if = 1'b1;
    tick();
    ena_from_if = 1'b0;
  endtask

  task automatic pulse_lsb(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size);
    wr_flag_from_lsb = wr;
    addr_from_lsb    = addr;
    data_from_lsb    = data;
    size_from_lsb    = size;
    ena_from_lsb     = 1'b1;
    tick();
    ena_from_lsb     = 1'b0;
  endtask

  initial begin
    int n;
    int snap_if, snap_lsb;
    bit wr_seen;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    ena_from_if = 1'b0; pc_from_if = '0; drop_flag_from_if = 1'b0;
    ena_from_lsb = 1'b0; wr_flag_from_lsb = 1'b0; addr_from_lsb = '0;
    data_from_lsb = '0; size_from_lsb = 2'd0; rollback_flag_from_rob = 1'b0;
    tick(); tick();
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_oks", {30'd0, ok_flag_to_if, ok_flag_to_lsb}, 32'd0);
    check("reset_data", inst_to_if | data_to_lsb | {24'd0, mem_dout}, 32'd0);
    rst = 1'b0;
    tick();

    // Word fetch from 0x100: ok five edges after the start edge.
    pulse_fetch(32'h100);
    check("fetch_a0", mem_a, 32'h100);
    wait_ok(1'b0, 20, n);
    check("fetch_latency", n, 32'd5);
    check("fetch_inst", inst_to_if, 32'h0000_0513);
    check("fetch_idle_a", mem_a, 32'd0);
    tick();
    check("fetch_ok_single", {31'd0, ok_flag_to_if}, 32'd0);
    check("fetch_ok_count", if_ok_cnt, 32'd1);

    // Contention: half load at 0x204 beats the fetch at 0x200.
    snap_if = if_ok_cnt; snap_lsb = lsb_ok_cnt;
    pc_from_if = 32'h200; ena_from_if = 1'b1;
    pulse_lsb(1'b0, 32'h204, 32'h0, 2'd1);
    ena_from_if = 1'b0;
    check("cont_first_a", mem_a, 32'h204);
    wait_ok(1'b1, 20, n);
    check("cont_lsb_latency", n, 32'd3);
    check("cont_lsb_data", data_to_lsb, 32'h0000_1234);
    check("cont_if_not_yet", {31'd0, ok_flag_to_if}, 32'd0);
    wait_ok(1'b0, 20, n);
    check("cont_if_latency", n, 32'd6);
    check("cont_if_inst", inst_to_if, 32'h0010_0093);
    tick(); tick();
    check("cont_if_count", if_ok_cnt - snap_if, 32'd1);
    check("cont_lsb_count", lsb_ok_cnt - snap_lsb, 32'd1);

    // Word store 0xDEADBEEF at 0x300, byte by byte.
    pulse_lsb(1'b1, 32'h300, 32'hDEAD_BEEF, 2'd2);
    check("st_b0", {mem_wr, mem_a[30:0], mem_dout}, {1'b1, 31'h300, 8'hEF});
    tick();
    check("st_b1", {mem_wr, mem_a[30:0], mem_dout}, {1'b1, 31'h301, 8'hBE});
    tick();
    check("st_b2", {mem_wr, mem_a[30:0], mem_dout}, {1'b1, 31'h302, 8'hAD});
    tick();
    check("st_b3", {mem_wr, mem_a[30:0], mem_dout}, {1'b1, 31'h303, 8'hDE});
    tick();
    check("st_done", {30'd0, mem_wr, ok_flag_to_lsb}, 32'd1);
    check("st_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'hDEAD_BEEF);
    tick();
    pulse_lsb(1'b0, 32'h300, 32'h0, 2'd2);
    wait_ok(1'b1, 20, n);
    check("rb_latency", n, 32'd5);
    check("rb_data", data_to_lsb, 32'hDEAD_BEEF);
    tick();

    // Drop a fetch at its third edge, then fetch 0x200 one cycle later.
    snap_if = if_ok_cnt;
    pulse_fetch(32'h100);
    tick();
    drop_flag_from_if = 1'b1;
    tick();
    drop_flag_from_if = 1'b0;
    check("drop_idle_a", mem_a, 32'd0);
    check("drop_no_ok", {31'd0, ok_flag_to_if}, 32'd0);
    pulse_fetch(32'h200);
    wait_ok(1'b0, 20, n);
    check("drop_refetch_latency", n, 32'd5);
    check("drop_refetch_inst", inst_to_if, 32'h0010_0093);
    tick(); tick();
    check("drop_ok_count", if_ok_cnt - snap_if, 32'd1);

    // Rollback during a word load.
    snap_lsb = lsb_ok_cnt;
    pulse_lsb(1'b0, 32'h300, 32'h0, 2'd2);
    tick(); tick();
    rollback_flag_from_rob = 1'b1;
    tick();
    rollback_flag_from_rob = 1'b0;
    check("rbk_idle_a", mem_a, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("rbk_no_ok", lsb_ok_cnt - snap_lsb, 32'd0);
    check("rbk_data_kept", data_to_lsb, 32'hDEAD_BEEF);

    // IO store stalled by a full UART buffer for 10 cycles.
    snap_lsb = lsb_ok_cnt;
    io_buffer_full = 1'b1;
    pulse_lsb(1'b1, 32'h0003_0000, 32'h0000_005A, 2'd0);
    wr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_wr !== 1'b0) wr_seen = 1'b1;
      tick();
    end
    check("io_stall_no_wr", {31'd0, wr_seen}, 32'd0);
    io_buffer_full = 1'b0;
    tick();
    check("io_wr", {mem_wr, mem_a[30:0], mem_dout}, {1'b1, 31'h0003_0000, 8'h5A});
    tick();
    check("io_done", {30'd0, mem_wr, ok_flag_to_lsb}, 32'd1);
    tick();
    check("io_ok_count", lsb_ok_cnt - snap_lsb, 32'd1);

    // rdy low for 3 cycles mid-fetch delays completion by exactly 3 edges.
    pulse_fetch(32'h100);
    tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    check("rdy_wr_low", {31'd0, mem_wr}, 32'd0);
    rdy = 1'b1;
    wait_ok(1'b0, 20, n);
    check("rdy_fetch_latency", n + 4, 32'd8);
    check("rdy_fetch_inst", inst_to_if, 32'h0000_0513);
    tick();

    // rdy low during a byte store masks mem_wr immediately.
    pulse_lsb(1'b1, 32'h320, 32'h0000_0077, 2'd0);
    check("rdy_st_wr", {31'd0, mem_wr}, 32'd1);
    rdy = 1'b0;
    #1;
    check("rdy_st_gated", {31'd0, mem_wr}, 32'd0);
    tick();
    rdy = 1'b1;
    #1;
    check("rdy_st_resume", {31'd0, mem_wr}, 32'd1);
    tick();
    check("rdy_st_ok", {31'd0, ok_flag_to_lsb}, 32'd1);
    check("rdy_st_ram", {24'd0, ram[12'h320]}, 32'h77);
    tick();

    // Synchronous reset in the middle of a word store.
    snap_lsb = lsb_ok_cnt;
    pulse_lsb(1'b1, 32'h310, 32'h1122_3344, 2'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_bus", {mem_wr, mem_a[30:0]}, 32'd0);
    check("rst_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_client", inst_to_if | data_to_lsb | {30'd0, ok_flag_to_if, ok_flag_to_lsb}, 32'd0);
    wr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_wr !== 1'b0 || mem_a !== 32'd0) wr_seen = 1'b1;
    end
    check("rst_pending_clear", {31'd0, wr_seen}, 32'd0);
    check("rst_no_ok", lsb_ok_cnt - snap_lsb, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that is the responder for the fetcher's instruction-request port and the load/store buffer's data port. It serialises 32-bit instruction fetches and 1/2/4-byte loads and stores onto the single byte-wide RAM/IO bus. It latches one-cycle request pulses, arbitrates between the two clients, and returns single-cycle ok pulses. Fetch abort (drop) and ROB rollback are honoured mid-transfer.

## Interface
- No parameters; widths come from `defines.v` (`ADDR_TYPE`=32, `INS_TYPE`=`DATA_TYPE`=32, `BYTE_TYPE`=8).
- clk  in  1  single clock; all state on posedge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- mem_din  in  8  RAM/IO read byte; valid the cycle after its address is presented
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full
- ena_from_if  in  1  fetch request pulse
- pc_from_if  in  32  fetch address
- drop_flag_from_if  in  1  abort the outstanding fetch
- ok_flag_to_if  out  1  one-cycle fetch-done pulse
- inst_to_if  out  32  fetched word, little-endian
- ena_from_lsb  in  1  data request pulse
- wr_flag_from_lsb  in  1  1 = store
- addr_from_lsb  in  32  data address
- data_from_lsb  in  32  store data; low bytes are used
- size_from_lsb  in  2  0 = byte, 1 = half, 2 = word
- ok_flag_to_lsb  out  1  one-cycle done pulse
- data_to_lsb  out  32  load result, zero-extended
- rollback_flag_from_rob  in  1  flush the outstanding load

## Operation
- **Reset values:** all outputs 0, all pending flags 0, state IDLE.
- **Request latching:** `ena_*` pulses are latched into `if_pending` / `lsb_pending` together with their address, size, data and write flag. Each client has at most one request outstanding.
- **States:** IDLE, IFETCH, LOAD, STORE.
- **IDLE to transfer:**
  - If an LSB request is pending, go to LOAD or STORE.
  - Otherwise, if a fetch is pending, go to IFETCH.
  - LSB has priority. A request that arrives at the same edge is started at that edge.
- **Byte counter:** `stage`, 0..n-1, where n = 4 for IFETCH and n = 1/2/4 from `size` for LOAD/STORE.
- **Read byte order:** byte i is taken from address base+i and assembled into bits [8i+7:8i].
- **Write byte order:** byte i is bits [8i+7:8i] of the store data, written to base+i.
- **Completion:** the state returns to IDLE and clears its pending flag. The matching `ok_flag` is high for exactly one cycle, with `inst_to_if` / `data_to_lsb` valid in that same cycle.
- **Drop:** `drop_flag_from_if` clears `if_pending`. If the state is IFETCH, it aborts to IDLE with no ok pulse. If `drop` and `ena_from_if` arrive at the same edge, the new request is kept.
- **Rollback:** `rollback_flag_from_rob` clears a pending load and aborts LOAD to IDLE with no ok pulse. STORE and pending stores are never cancelled, because LSB only issues committed stores.
- **IO stall:** a store with `addr[17:16]==2'b11` does not start while `io_buffer_full` is high. The controller waits in IDLE and does not serve fetches, to keep order.
- **Idle outputs:** `mem_wr` = 0 and `mem_a` = 0 whenever the state is IDLE.
- **Not ready:** while `rdy` is low, `mem_wr` is gated to 0 combinationally and no state changes.

## Timing
- Edge E0 is the edge at which the transfer starts.
- **Read of n bytes:**
  - `mem_a` = base+i is registered at E(i).
  - Byte i is captured at E(i+2).
  - `ok` is registered at E(n+1): word at E5, half at E3, byte at E2.
  - State is IDLE from E(n+1). The next transfer can start at E(n+2).
- **Write of n bytes:**
  - `mem_wr`=1, `mem_a`=base+i and `mem_dout`=byte i are registered at E(i).
  - At E(n), `mem_wr`<=0 and `ok` is raised. Word store: ok at E4.
- **Single-pulse ok:** `ok_flag` drops at the following edge.

## Structure
- Add to `defines.v`: `BYTE_TYPE`, `DATA_TYPE`, the size encodings `SIZE_B/H/W`, the mem_ctrl state encodings, and the IO address predicate constant.
- There is no sub-module: byte assembly and counters are inline. A client-request latch is too thin to split out.

## Test plan
- **Fetch:** RAM[0x100..0x103] = 13 05 00 00, pulse ena_from_if with pc 0x100 -> ok_flag_to_if one cycle, 5 edges later, inst_to_if = 0x00000513.
- **Contention:** fetch and lsb load of half 0x204 (bytes 34 12) pulsed together -> LSB served first, data_to_lsb = 0x00001234, then the fetch completes. Exactly one ok per client.
- **Word store:** store word 0xDEADBEEF at 0x300 -> four mem_wr cycles writing EF BE AD DE to 0x300..0x303, ok_flag_to_lsb at E4. A readback load returns 0xDEADBEEF.
- **Drop:** drop_flag_from_if at stage 2 of a fetch -> no ok_flag_to_if, state IDLE, mem_a = 0. A new fetch to 0x200 pulsed one cycle later completes normally.
- **Rollback and IO stall:**
  - Rollback during a word load -> no ok_flag_to_lsb.
  - A byte store to 0x30000 while io_buffer_full=1 for 10 cycles -> mem_wr stays 0 until full drops, then one write with ok.
- **Reset / rdy:**
  - rst mid-store -> all outputs 0 next cycle and pending flags cleared.
  - rdy low for 3 cycles mid-fetch -> mem_wr 0, completion delayed by exactly 3 cycles.
